// File: rtl/frame_writeback_if.sv
// Handshake bundle between the filter engine, frame_writeback and the host side.
//   in_valid/in_pixel/in_ready    : signed convolution results into the block
//   out_valid/out_pixel/out_ready : stored pixels streamed back out
// Modports:
//   slave  : the frame_writeback block itself
//   master : the environment that supplies results and consumes pixels
interface frame_writeback_if #(
  parameter int IN_W  = 12,
  parameter int PIX_W = 8
);
  logic                    in_valid;
  logic signed [IN_W-1:0]  in_pixel;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [PIX_W-1:0]        out_pixel;

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_pixel
  );

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_pixel
  );
endinterface

// File: rtl/frame_writeback.sv
// Write-back end of the 3x3 filter datapath. Clamps each signed result to an
// unsigned pixel, stores a full IMG_W x IMG_H frame in raster order, then
// streams the frame back out in raster order.
// Ports:
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   start      : one-cycle pulse, begins a frame (honoured only in IDLE)
//   busy       : high whenever the FSM is not in IDLE
//   frame_done : one-cycle pulse after the final output handshake
//   bus        : input/output valid-ready streams (frame_writeback_if.slave)
//
// state   | meaning
// IDLE    | waiting for start, no traffic accepted or offered
// COLLECT | accepting IMG_W*IMG_H results into the frame buffer
// DRAIN   | streaming the buffer out, one-cycle registered read
// DONE    | frame_done pulse, returns to IDLE
module frame_writeback #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int IN_W  = 12,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               frame_done,
  frame_writeback_if.slave   bus
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int AW   = $clog2(NPIX);
  // Read-issue pointer must reach NPIX to mark "everything fetched".
  localparam int RCW  = $clog2(NPIX + 1);
  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    wr_col_q, wr_col_d;
  logic [RW-1:0]    wr_row_q, wr_row_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [RCW-1:0]   rd_addr_q, rd_addr_d;
  logic [AW-1:0]    rd_cnt_q, rd_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_pixel_q, out_pixel_d;

  logic [PIX_W-1:0] mem [NPIX];
  logic             mem_we;
  logic [PIX_W-1:0] clamp_pix;
  logic [PIX_W-1:0] mem_rdata;
  logic             accept;
  logic             out_hs;
  logic             out_adv;

  // Negative -> 0; anything with bits set above the pixel range -> max.
  always_comb begin
    clamp_pix = bus.in_pixel[PIX_W-1:0];
    if (bus.in_pixel[IN_W-1]) begin
      clamp_pix = '0;
    end else if (|bus.in_pixel[IN_W-2:PIX_W]) begin
      clamp_pix = PIX_MAX;
    end
  end

  assign accept    = (state_q == COLLECT) && bus.in_valid && in_ready_q;
  assign mem_we    = accept && !rst;
  assign out_hs    = out_valid_q && bus.out_ready;
  // The output register may load a new pixel when it is empty or being taken;
  // otherwise it simply holds, which keeps out_pixel stable under stall.
  assign out_adv   = !out_valid_q || bus.out_ready;
  assign mem_rdata = mem[rd_addr_q[AW-1:0]];

  always_comb begin
    state_d     = state_q;
    wr_col_d    = wr_col_q;
    wr_row_d    = wr_row_q;
    wr_ptr_d    = wr_ptr_q;
    rd_addr_d   = rd_addr_q;
    rd_cnt_d    = rd_cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = COLLECT;
          in_ready_d = 1'b1;
          wr_col_d   = '0;
          wr_row_d   = '0;
          wr_ptr_d   = '0;
          rd_addr_d  = '0;
          rd_cnt_d   = '0;
        end
      end

      COLLECT: begin
        if (accept) begin
          if (wr_ptr_q == AW'(NPIX - 1)) begin
            state_d    = DRAIN;
            in_ready_d = 1'b0;
          end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (wr_col_q == CW'(IMG_W - 1)) begin
              wr_col_d = '0;
              wr_row_d = wr_row_q + RW'(1);
            end else begin
              wr_col_d = wr_col_q + CW'(1);
            end
          end
        end
      end

      DRAIN: begin
        if (out_adv) begin
          if (rd_addr_q < RCW'(NPIX)) begin
            out_pixel_d = mem_rdata;
            out_valid_d = 1'b1;
            rd_addr_d   = rd_addr_q + RCW'(1);
          end else begin
            out_valid_d = 1'b0;
          end
        end
        if (out_hs) begin
          if (rd_cnt_q == AW'(NPIX - 1)) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
          end else begin
            rd_cnt_d = rd_cnt_q + AW'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_col_q    <= '0;
      wr_row_q    <= '0;
      wr_ptr_q    <= '0;
      rd_addr_q   <= '0;
      rd_cnt_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_col_q    <= wr_col_d;
      wr_row_q    <= wr_row_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_addr_q   <= rd_addr_d;
      rd_cnt_q    <= rd_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
    end
  end

  // Frame buffer is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= clamp_pix;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pixel = out_pixel_q;
  assign busy          = (state_q != IDLE);
  assign frame_done    = (state_q == DONE);

endmodule

// File: tb/tb_frame_writeback.sv
// Directed bench: three instances (4x1 clamp, 4x3 raster/start/reset,
// 64x64 backpressure). Inputs driven and outputs sampled on the falling edge.
module tb_frame_writeback;

  logic clk = 1'b0;
  logic rst;
  logic st_a, st_b, st_c;
  logic busy_a, busy_b, busy_c;
  logic fd_a, fd_b, fd_c;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  frame_writeback_if #(.IN_W(12), .PIX_W(8)) ifa ();
  frame_writeback_if #(.IN_W(12), .PIX_W(8)) ifb ();
  frame_writeback_if #(.IN_W(12), .PIX_W(8)) ifc ();

  frame_writeback #(.IMG_W(4), .IMG_H(1), .IN_W(12), .PIX_W(8)) u_a (
    .clk(clk), .rst(rst), .start(st_a), .busy(busy_a), .frame_done(fd_a), .bus(ifa.slave)
  );
  frame_writeback #(.IMG_W(4), .IMG_H(3), .IN_W(12), .PIX_W(8)) u_b (
    .clk(clk), .rst(rst), .start(st_b), .busy(busy_b), .frame_done(fd_b), .bus(ifb.slave)
  );
  frame_writeback #(.IMG_W(64), .IMG_H(64), .IN_W(12), .PIX_W(8)) u_c (
    .clk(clk), .rst(rst), .start(st_c), .busy(busy_c), .frame_done(fd_c), .bus(ifc.slave)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  int clamp_in  [4] = '{-5, 300, 128, 255};
  int clamp_exp [4] = '{0, 255, 128, 255};

  initial begin
    int n, fd, hs, held;
    logic stalled;

    rst = 1'b1;
    st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_pixel = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_pixel = '0; ifb.out_ready = 1'b0;
    ifc.in_valid = 1'b0; ifc.in_pixel = '0; ifc.out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_in_ready", ifa.in_ready, 0);
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_out_pixel", ifa.out_pixel, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_frame_done", fd_a, 0);

    st_a = 1'b1;
    tick();
    st_a = 1'b0;
    chk("start_in_ready", ifa.in_ready, 1);
    chk("start_busy", busy_a, 1);

    // clamp, 4x1
    for (int i = 0; i < 4; i++) begin
      chk("a_rdy", ifa.in_ready, 1);
      ifa.in_valid = 1'b1;
      ifa.in_pixel = 12'(clamp_in[i]);
      tick();
    end
    ifa.in_valid = 1'b0;
    chk("a_rdy_drop", ifa.in_ready, 0);
    ifa.out_ready = 1'b1;
    n = 0; fd = 0;
    for (int c = 0; c < 20; c++) begin
      if (ifa.out_valid) begin
        if (n < 4) chk("a_clamp_pix", ifa.out_pixel, clamp_exp[n]);
        n++;
      end
      if (fd_a) fd++;
      tick();
    end
    chk("a_out_count", n, 4);
    chk("a_done_pulses", fd, 1);
    chk("a_busy_end", busy_a, 0);

    // raster order 4x3, in_valid every other cycle, start pulses ignored
    st_b = 1'b1;
    tick();
    st_b = 1'b0;
    chk("b_busy", busy_b, 1);
    for (int k = 0; k < 12; k++) begin
      ifb.in_valid = 1'b0;
      if (k == 5) st_b = 1'b1;
      tick();
      st_b = 1'b0;
      chk("b_rdy", ifb.in_ready, 1);
      ifb.in_valid = 1'b1;
      ifb.in_pixel = 12'(k);
      tick();
    end
    ifb.in_valid = 1'b0;
    chk("b_rdy_drop", ifb.in_ready, 0);
    chk("b_valid_c1", ifb.out_valid, 0);
    tick();
    chk("b_valid_c2", ifb.out_valid, 1);
    chk("b_first_pix", ifb.out_pixel, 0);
    ifb.out_ready = 1'b1;
    n = 0; fd = 0;
    for (int c = 0; c < 40; c++) begin
      st_b = (c == 3);
      if (ifb.out_valid) begin
        chk("b_raster_pix", ifb.out_pixel, n);
        n++;
      end
      if (fd_b) fd++;
      tick();
    end
    st_b = 1'b0;
    chk("b_out_count", n, 12);
    chk("b_done_pulses", fd, 1);
    chk("b_busy_end", busy_b, 0);

    // start in IDLE begins a new frame; reset after 5 inputs discards it
    st_b = 1'b1;
    tick();
    st_b = 1'b0;
    chk("b2_in_ready", ifb.in_ready, 1);
    chk("b2_busy", busy_b, 1);
    for (int k = 0; k < 5; k++) begin
      ifb.in_valid = 1'b1;
      ifb.in_pixel = 12'(50 + k);
      tick();
    end
    ifb.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", ifb.in_ready, 0);
    chk("mid_rst_busy", busy_b, 0);
    chk("mid_rst_out_valid", ifb.out_valid, 0);
    chk("mid_rst_out_pixel", ifb.out_pixel, 0);
    chk("mid_rst_frame_done", fd_b, 0);
    tick();
    chk("mid_rst_still_idle", ifb.in_ready, 0);

    st_b = 1'b1;
    tick();
    st_b = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("b3_rdy", ifb.in_ready, 1);
      ifb.in_valid = 1'b1;
      ifb.in_pixel = 12'(200 + k);
      tick();
    end
    ifb.in_valid = 1'b0;
    n = 0; fd = 0;
    for (int c = 0; c < 40; c++) begin
      if (ifb.out_valid) begin
        chk("b3_new_pix", ifb.out_pixel, 200 + n);
        n++;
      end
      if (fd_b) fd++;
      tick();
    end
    chk("b3_out_count", n, 12);
    chk("b3_done_pulses", fd, 1);

    // 64x64 with random backpressure
    st_c = 1'b1;
    tick();
    st_c = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_pixel = 12'(((i / 64) + (i % 64)) % 256);
      tick();
    end
    ifc.in_valid = 1'b0;
    chk("c_rdy_drop", ifc.in_ready, 0);
    hs = 0; fd = 0; stalled = 1'b0; held = 0;
    for (int c = 0; c < 20000 && fd == 0; c++) begin
      if (stalled) begin
        chk("c_hold_valid", ifc.out_valid, 1);
        chk("c_hold_pix", ifc.out_pixel, held);
      end
      ifc.out_ready = 1'($urandom_range(0, 1));
      if (ifc.out_valid && ifc.out_ready) begin
        chk("c_data", ifc.out_pixel, ((hs / 64) + (hs % 64)) % 256);
        hs++;
      end
      stalled = ifc.out_valid && !ifc.out_ready;
      held = ifc.out_pixel;
      if (fd_c) fd++;
      tick();
    end
    chk("c_handshakes", hs, 4096);
    chk("c_done_pulses", fd, 1);
    chk("c_busy_end", busy_c, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
